// File: rtl/crossbar_scheduler.sv
// crossbar_scheduler: alternating FETCH/GRANT scheduler that moves each input queue's head word to its output RAM.
// Optional macro SCHED_RR_EN selects per-output round-robin arbitration; without it the lowest input index wins.
module crossbar_scheduler #(
   parameter int NPORTS       = 3,
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int DEST_W       = 2,
   parameter int DEFAULT_PORT = 1,
   parameter int SEL_W        = $clog2(NPORTS + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NPORTS*DATA_W-1:0] in_data,
   input  logic [NPORTS*ADDR_W-1:0] in_wr_addr,
   input  logic [NPORTS-1:0]        out_ready,
   output logic [NPORTS*ADDR_W-1:0] in_rd_addr,
   output logic [NPORTS-1:0]        in_rden,
   output logic [NPORTS*SEL_W-1:0]  mux_sel,
   output logic [NPORTS-1:0]        out_wr,
   output logic [NPORTS-1:0]        drop_pulse
);

   typedef enum logic {FETCH, GRANT} phase_t;

   phase_t                         phase;
   phase_t                         phase_next;
   logic [NPORTS-1:0]              not_empty;
   logic [NPORTS-1:0]              ne_q;
   logic [NPORTS-1:0]              consume;
   logic [NPORTS-1:0]              won;
   logic [NPORTS-1:0][NPORTS-1:0]  req;
   logic [DATA_W-1:0]              head;
   int                             dest;
   logic                           found;
   logic                           grant_ok;

`ifdef SCHED_RR_EN
   logic [NPORTS-1:0][SEL_W-1:0]   rr_ptr;
   logic [NPORTS-1:0][SEL_W-1:0]   rr_next;
`endif

   always_comb begin
      not_empty = '0;
      for (int i = 0; i < NPORTS; i++)
         not_empty[i] = in_rd_addr[i*ADDR_W +: ADDR_W] != in_wr_addr[i*ADDR_W +: ADDR_W];
   end

   // Strobes are gated with rst_n so nothing fires during a reset cycle, even mid-grant.
   assign in_rden = (rst_n && phase == FETCH) ? not_empty : '0;

   always_comb begin
      phase_next = (phase == FETCH) ? GRANT : FETCH;
   end

   // Queue occupancy is frozen at FETCH so a writer moving in_wr_addr during GRANT cannot disturb the grant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase      <= FETCH;
         ne_q       <= '0;
         in_rd_addr <= '0;
      end else begin
         phase <= phase_next;
         if (phase == FETCH)
            ne_q <= not_empty;
         for (int i = 0; i < NPORTS; i++)
            if (consume[i] || won[i])
               in_rd_addr[i*ADDR_W +: ADDR_W] <= in_rd_addr[i*ADDR_W +: ADDR_W] + ADDR_W'(1);
      end
   end

   // Head-word decode: fillers and invalid destinations are consumed without requesting an output.
   always_comb begin
      req        = '0;
      consume    = '0;
      drop_pulse = '0;
      head       = '0;
      dest       = 0;
      if (rst_n && phase == GRANT) begin
         for (int i = 0; i < NPORTS; i++) begin
            if (ne_q[i]) begin
               head = in_data[i*DATA_W +: DATA_W];
               dest = int'(head[DEST_W-1:0]);
               if (head == '0) begin
                  consume[i] = 1'b1;
               end else if (dest > NPORTS) begin
                  consume[i]    = 1'b1;
                  drop_pulse[i] = 1'b1;
               end else begin
                  for (int j = 0; j < NPORTS; j++)
                     req[j][i] = (dest == 0) ? (j == DEFAULT_PORT) : (dest == j + 1);
               end
            end
         end
      end
   end

   // Per-output arbitration: scan priority slots k in order and take the first ready requester.
   always_comb begin
      out_wr   = '0;
      mux_sel  = '0;
      won      = '0;
      found    = 1'b0;
      grant_ok = 1'b0;
`ifdef SCHED_RR_EN
      rr_next  = rr_ptr;
`endif
      for (int j = 0; j < NPORTS; j++) begin
         found = 1'b0;
         for (int k = 0; k < NPORTS; k++) begin
            for (int i = 0; i < NPORTS; i++) begin
`ifdef SCHED_RR_EN
               grant_ok = ((int'(rr_ptr[j]) + k) % NPORTS) == i;
`else
               grant_ok = (k == i);
`endif
               if (grant_ok && !found && out_ready[j] && req[j][i]) begin
                  found                     = 1'b1;
                  out_wr[j]                 = 1'b1;
                  mux_sel[j*SEL_W +: SEL_W] = SEL_W'(i + 1);
                  won[i]                    = 1'b1;
`ifdef SCHED_RR_EN
                  rr_next[j]                = SEL_W'((i + 1) % NPORTS);
`endif
               end
            end
         end
      end
   end

`ifdef SCHED_RR_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= '0;
      else
         rr_ptr <= rr_next;
   end
`endif

endmodule
